// File: rtl/note_display_sequencer.sv
// ---------------------------------------------------------------------------
// note_display_sequencer
//
// Feeds the note glyph drawer. Each accepted note gets the next slot on a
// COLS x ROWS grid. The note goes to the drawer with a one-cycle ld_note,
// and the block then waits out the drawer's fixed draw time. The block also
// owns full-screen clears: it drives its own pixel port while clr_active_o
// is high.
//
// Ports
//   clk_i, resetn_i        system clock, asynchronous active-low reset
//   note_valid_i           one-cycle strobe, note_in_i/octave_in_i valid
//   note_in_i, octave_in_i note code (1..12 = A..G#), octave code
//   clear_req_i            one-cycle screen clear request
//   ready_o                high only while idle (notes accepted)
//   note_o, octave_o       note/octave to the drawer, held between loads
//   x_o, y_o               slot origin to the drawer, held between loads
//   ld_note_o              one-cycle load pulse to the drawer
//   clr_active_o           clear sweep in progress
//   px_x_o, px_y_o         clear sweep pixel position
//   px_we_o, px_colour_o   clear sweep write enable and colour (black)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_CLEAR   | sweep every pixel with colour 0, then reset the slot grid
// S_IDLE    | ready; wait for a note or a clear request
// S_LOAD    | one cycle: ld_note to the drawer with registered note/x/y
// S_DRAW    | wait DRAW_CYCLES for the drawer; latch any clear request
// S_ADVANCE | step to the next slot; clear on full grid or pending clear
// ---------------------------------------------------------------------------
module note_display_sequencer #(
   parameter int SLOT_W      = 40,
   parameter int ROW_H       = 14,
   parameter int COLS        = 4,
   parameter int ROWS        = 8,
   parameter int DRAW_CYCLES = 146,
   parameter int SCREEN_W    = 160,
   parameter int SCREEN_H    = 120
) (
   input  logic       clk_i,
   input  logic       resetn_i,
   input  logic       note_valid_i,
   input  logic [3:0] note_in_i,
   input  logic [1:0] octave_in_i,
   input  logic       clear_req_i,
   output logic       ready_o,
   output logic [3:0] note_o,
   output logic [1:0] octave_o,
   output logic [7:0] x_o,
   output logic [6:0] y_o,
   output logic       ld_note_o,
   output logic       clr_active_o,
   output logic [7:0] px_x_o,
   output logic [6:0] px_y_o,
   output logic       px_we_o,
   output logic [2:0] px_colour_o
);

   localparam int COL_W = $clog2(COLS);
   localparam int ROW_W = $clog2(ROWS);
   localparam int CNT_W = $clog2(DRAW_CYCLES);

   typedef enum logic [2:0] {
      S_CLEAR,
      S_IDLE,
      S_LOAD,
      S_DRAW,
      S_ADVANCE
   } state_t;

   state_t             state_q, state_d;
   logic [COL_W-1:0]   col_q, col_d;
   logic [ROW_W-1:0]   row_q, row_d;
   logic               pend_q, pend_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [3:0]         note_q, note_d;
   logic [1:0]         oct_q, oct_d;
   logic [7:0]         x_q, x_d;
   logic [6:0]         y_q, y_d;
   logic               clr_q, clr_d;
   logic [7:0]         px_x_q, px_x_d;
   logic [6:0]         px_y_q, px_y_d;

   logic note_ok;
   logic col_last;
   logic row_last;

   assign note_ok  = (note_in_i >= 4'd1) && (note_in_i <= 4'd12);
   assign col_last = (col_q == COL_W'(COLS - 1));
   assign row_last = (row_q == ROW_W'(ROWS - 1));

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q <= S_CLEAR;
         col_q   <= '0;
         row_q   <= '0;
         pend_q  <= 1'b0;
         cnt_q   <= '0;
         note_q  <= '0;
         oct_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         clr_q   <= 1'b0;
         px_x_q  <= '0;
         px_y_q  <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
         note_q  <= note_d;
         oct_q   <= oct_d;
         x_q     <= x_d;
         y_q     <= y_d;
         clr_q   <= clr_d;
         px_x_q  <= px_x_d;
         px_y_q  <= px_y_d;
      end
   end

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      pend_d  = pend_q;
      cnt_d   = cnt_q;
      note_d  = note_q;
      oct_d   = oct_q;
      x_d     = x_q;
      y_d     = y_q;
      clr_d   = clr_q;
      px_x_d  = px_x_q;
      px_y_d  = px_y_q;

      unique case (state_q)
         S_CLEAR: begin
            if (!clr_q) begin
               // Only reachable straight out of reset: outputs must read 0
               // during reset, so the sweep starts on the first clock after.
               clr_d  = 1'b1;
               px_x_d = '0;
               px_y_d = '0;
            end else if (px_x_q == 8'(SCREEN_W - 1)) begin
               px_x_d = '0;
               if (px_y_q == 7'(SCREEN_H - 1)) begin
                  state_d = S_IDLE;
                  clr_d   = 1'b0;
                  px_y_d  = '0;
                  col_d   = '0;
                  row_d   = '0;
                  pend_d  = 1'b0;
               end else begin
                  px_y_d = px_y_q + 7'd1;
               end
            end else begin
               px_x_d = px_x_q + 8'd1;
            end
         end

         S_IDLE: begin
            if (clear_req_i) begin
               state_d = S_CLEAR;
               clr_d   = 1'b1;
               px_x_d  = '0;
               px_y_d  = '0;
            end else if (note_valid_i && note_ok) begin
               state_d = S_LOAD;
               note_d  = note_in_i;
               oct_d   = octave_in_i;
               x_d     = 8'(int'(col_q) * SLOT_W);
               y_d     = 7'(int'(row_q) * ROW_H);
            end
         end

         S_LOAD: begin
            state_d = S_DRAW;
            cnt_d   = CNT_W'(DRAW_CYCLES - 1);
            if (clear_req_i) pend_d = 1'b1;
         end

         S_DRAW: begin
            if (clear_req_i) pend_d = 1'b1;
            if (cnt_q == '0) begin
               state_d = S_ADVANCE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         S_ADVANCE: begin
            if (col_last) begin
               col_d = '0;
               row_d = row_last ? '0 : row_q + ROW_W'(1);
            end else begin
               col_d = col_q + COL_W'(1);
            end
            if ((col_last && row_last) || pend_q) begin
               state_d = S_CLEAR;
               clr_d   = 1'b1;
               px_x_d  = '0;
               px_y_d  = '0;
            end else begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_CLEAR;
            clr_d   = 1'b0;
         end
      endcase
   end

   assign ready_o      = (state_q == S_IDLE);
   assign ld_note_o    = (state_q == S_LOAD);
   assign note_o       = note_q;
   assign octave_o     = oct_q;
   assign x_o          = x_q;
   assign y_o          = y_q;
   assign clr_active_o = clr_q;
   assign px_we_o      = clr_q;
   assign px_x_o       = px_x_q;
   assign px_y_o       = px_y_q;
   assign px_colour_o  = 3'b000;

endmodule

// File: tb/tb_note_display_sequencer.sv
`timescale 1ns/1ps
module tb_note_display_sequencer;

   localparam int SW    = 160;
   localparam int SH    = 120;
   localparam int SWEEP = SW * SH;
   localparam int BUSY  = 148;

   logic       clk = 1'b0;
   logic       resetn;
   logic       note_valid;
   logic [3:0] note_in;
   logic [1:0] octave_in;
   logic       clear_req;
   logic       ready;
   logic [3:0] note;
   logic [1:0] octave;
   logic [7:0] x;
   logic [6:0] y;
   logic       ld_note;
   logic       clr_active;
   logic [7:0] px_x;
   logic [6:0] px_y;
   logic       px_we;
   logic [2:0] px_colour;

   always #5 clk = ~clk;

   note_display_sequencer dut (
      .clk_i        (clk),
      .resetn_i     (resetn),
      .note_valid_i (note_valid),
      .note_in_i    (note_in),
      .octave_in_i  (octave_in),
      .clear_req_i  (clear_req),
      .ready_o      (ready),
      .note_o       (note),
      .octave_o     (octave),
      .x_o          (x),
      .y_o          (y),
      .ld_note_o    (ld_note),
      .clr_active_o (clr_active),
      .px_x_o       (px_x),
      .px_y_o       (px_y),
      .px_we_o      (px_we),
      .px_colour_o  (px_colour)
   );

   typedef struct packed {
      logic [3:0] n;
      logic [1:0] o;
      logic [7:0] x;
      logic [6:0] y;
   } ld_t;

   ld_t exp_q[$];
   int  total = 0;
   int  bad = 0;
   int  slot_k = 0;
   int  sweeps_done = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Monitor: pops expected loads on ld_note and checks clear sweeps.
   initial begin : monitor
      logic prev_ld;
      logic prev_clr;
      int   pix;
      int   pix_err;
      ld_t  e;
      prev_ld = 1'b0; prev_clr = 1'b0; pix = 0; pix_err = 0;
      forever begin
         @(negedge clk);
         if (resetn !== 1'b1) begin
            prev_ld = 1'b0; prev_clr = 1'b0; pix = 0; pix_err = 0;
         end else begin
            if (ld_note) begin
               check("ld_width", 64'(prev_ld), 64'd0);
               if (!prev_ld) begin
                  if (exp_q.size() == 0) begin
                     check("ld_unexpected", 64'd1, 64'd0);
                  end else begin
                     e = exp_q.pop_front();
                     check("ld_fields", 64'({note, octave, x, y}), 64'(e));
                  end
               end
            end
            if (clr_active) begin
               if (px_x !== 8'(pix % SW) || px_y !== 7'(pix / SW) ||
                   px_we !== 1'b1 || px_colour !== 3'b000)
                  pix_err++;
               pix++;
            end else if (prev_clr) begin
               check("sweep_len", 64'(pix), 64'(SWEEP));
               check("sweep_pixels", 64'(pix_err), 64'd0);
               check("ready_after_clear", 64'(ready), 64'd1);
               check("we_after_clear", 64'(px_we), 64'd0);
               sweeps_done++;
               pix = 0;
               pix_err = 0;
            end
            prev_ld  = ld_note;
            prev_clr = clr_active;
         end
      end
   end

   // Issue one transaction in an idle cycle and update the slot model.
   task automatic send(input logic [3:0] n, input logic [1:0] o, input bit with_clr);
      bit  got_ready;
      ld_t e;
      got_ready = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (ready === 1'b1) begin
            got_ready = 1'b1;
            break;
         end
      end
      if (!got_ready) begin
         check("ready_timeout", 64'd0, 64'd1);
         return;
      end
      note_valid = 1'b1;
      note_in    = n;
      octave_in  = o;
      clear_req  = with_clr;
      if (with_clr) begin
         slot_k = 0;
      end else if (n >= 4'd1 && n <= 4'd12) begin
         e = {n, o, 8'((slot_k % 4) * 40), 7'((slot_k / 4) * 14)};
         exp_q.push_back(e);
         slot_k = (slot_k + 1) % 32;
      end
      @(posedge clk);
      #1;
      note_valid = 1'b0;
      clear_req  = 1'b0;
      note_in    = '0;
      octave_in  = '0;
   endtask

   // Count cycles until ready (or clr_active) rises; optional clear_req pulse.
   task automatic count_low(input int pulse_at, input bit use_clr, output int cnt);
      cnt = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         clear_req = (i == pulse_at);
         if ((use_clr ? clr_active : ready) === 1'b1) break;
         cnt++;
      end
      clear_req = 1'b0;
   endtask

   task automatic wait_sweep();
      int s;
      s = sweeps_done;
      for (int i = 0; i < SWEEP + 800; i++) begin
         @(negedge clk);
         if (sweeps_done != s) break;
      end
      check("sweep_wait", 64'(sweeps_done != s), 64'd1);
   endtask

   function automatic logic [3:0] rnote();
      return 4'($urandom_range(1, 12));
   endfunction

   function automatic logic [1:0] roct();
      return 2'($urandom_range(0, 3));
   endfunction

   initial begin : stim
      int c;
      resetn = 1'b0; note_valid = 1'b0; note_in = '0; octave_in = '0; clear_req = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs", 64'({ready, ld_note, note, octave, x, y, clr_active,
                                  px_x, px_y, px_we, px_colour}), 64'd0);
      resetn = 1'b1;
      wait_sweep();

      // clear_req and note_valid together: clear wins, note dropped
      send(4'd3, 2'd1, 1'b1);
      @(negedge clk);
      check("simul_clr_start", 64'(clr_active), 64'd1);
      check("simul_ready_low", 64'(ready), 64'd0);
      wait_sweep();

      send(4'd5, 2'd2, 1'b0);
      count_low(-1, 1'b0, c);
      check("ready_low_cycles", 64'(c), 64'(BUSY));
      for (int i = 0; i < 4; i++) send(rnote(), roct(), 1'b0);

      send(4'd0, roct(), 1'b0);
      @(negedge clk);
      check("inv0_ready", 64'(ready), 64'd1);
      send(4'd13, roct(), 1'b0);
      @(negedge clk);
      check("inv13_ready", 64'(ready), 64'd1);
      send(4'($urandom_range(14, 15)), roct(), 1'b0);
      @(negedge clk);
      check("inv_hi_ready", 64'(ready), 64'd1);

      // fill the grid: slots 5..30, then the 32nd triggers an automatic clear
      for (int i = 5; i < 31; i++) send(rnote(), roct(), 1'b0);
      send(rnote(), roct(), 1'b0);
      count_low(-1, 1'b1, c);
      check("auto_clear_delay", 64'(c), 64'(BUSY));
      wait_sweep();

      // slot (0,0), then clear_req during the draw of slot (40,0)
      send(rnote(), roct(), 1'b0);
      send(rnote(), roct(), 1'b0);
      count_low(10, 1'b1, c);
      slot_k = 0;
      check("pend_clear_delay", 64'(c), 64'(BUSY));
      wait_sweep();

      // next note back at (0,0), then reset during its draw
      send(rnote(), roct(), 1'b0);
      repeat (20) @(negedge clk);
      check("loads_drained", 64'(exp_q.size()), 64'd0);
      resetn = 1'b0;
      #1;
      check("reset_mid_draw", 64'({ready, ld_note, note, octave, x, y, clr_active,
                                   px_x, px_y, px_we, px_colour}), 64'd0);
      slot_k = 0;
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      repeat (5) @(negedge clk);
      check("post_reset_clearing", 64'(clr_active), 64'd1);
      check("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #1_500_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
